// File: rtl/maze_pixel_renderer_if.sv
// Control, maze-memory and LCD pixel-port signals of the maze pixel renderer.
// The renderer uses the master view; its environment uses the slave view.
interface maze_pixel_renderer_if;
    logic        start;
    logic        gen_end;
    logic [4:0]  player_x;
    logic [5:0]  player_y;
    logic [4:0]  exit_x;
    logic [5:0]  exit_y;
    logic [10:0] maze_address;
    logic        maze_address_data;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        busy;
    logic        frame_done;

    modport master (
        input  start, gen_end, player_x, player_y, exit_x, exit_y,
        input  maze_address_data, pixelReady,
        output maze_address, xAddr, yAddr, pixelData, pixelWrite, busy, frame_done
    );

    modport slave (
        output start, gen_end, player_x, player_y, exit_x, exit_y,
        output maze_address_data, pixelReady,
        input  maze_address, xAddr, yAddr, pixelData, pixelWrite, busy, frame_done
    );
endinterface

// File: rtl/maze_pixel_renderer.sv
// Raster-scans the LCD once per frame, reading one wall bit per maze cell per pixel row
// and colouring each pixel by player, exit or wall/floor priority.
module maze_pixel_renderer #(
    parameter int          WIDTH         = 240,
    parameter int          HEIGHT        = 320,
    parameter int          CELL_BITS     = 3,
    parameter int          MAZE_W        = 30,
    parameter int          MAZE_H        = 40,
    parameter int          READ_LATENCY  = 1,
    parameter logic [15:0] WALL_COLOUR   = 16'h0000,
    parameter logic [15:0] FLOOR_COLOUR  = 16'h07E0,
    parameter logic [15:0] PLAYER_COLOUR = 16'hF800,
    parameter logic [15:0] EXIT_COLOUR   = 16'h001F
) (
    input  logic                  clock,
    input  logic                  reset,
    maze_pixel_renderer_if.master bus
);
    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, ADVANCE, DONE} state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [7:0]     x_addr;
    logic [8:0]     y_addr;
    logic [10:0]    maze_addr;
    logic [15:0]    pixel_data;
    logic           pixel_write;
    logic           busy_q;
    logic           frame_done_q;
    logic           cell_wall;
    logic [4:0]     lat_px;
    logic [5:0]     lat_py;
    logic [4:0]     lat_ex;
    logic [5:0]     lat_ey;

    logic [7:0]     next_x;
    logic [8:0]     next_y;
    logic           last_pixel;

    function automatic logic [10:0] cell_index(input logic [7:0] x, input logic [8:0] y);
        return 11'(x >> CELL_BITS) + 11'(MAZE_W) * 11'(y >> CELL_BITS);
    endfunction

    // Off-grid player/exit coordinates fail the range test and never match.
    function automatic logic [15:0] colour_of(input logic [7:0] x, input logic [8:0] y,
                                              input logic wall);
        logic [10:0] cx, cy;
        cx = 11'(x >> CELL_BITS);
        cy = 11'(y >> CELL_BITS);
        if (11'(lat_px) < 11'(MAZE_W) && 11'(lat_py) < 11'(MAZE_H) &&
            cx == 11'(lat_px) && cy == 11'(lat_py))
            return PLAYER_COLOUR;
        else if (11'(lat_ex) < 11'(MAZE_W) && 11'(lat_ey) < 11'(MAZE_H) &&
                 cx == 11'(lat_ex) && cy == 11'(lat_ey))
            return EXIT_COLOUR;
        else
            return wall ? WALL_COLOUR : FLOOR_COLOUR;
    endfunction

    always_comb begin
        last_pixel = (x_addr == 8'(WIDTH - 1)) && (y_addr == 9'(HEIGHT - 1));
        next_x     = x_addr + 8'd1;
        next_y     = y_addr;
        if (x_addr == 8'(WIDTH - 1)) begin
            next_x = 8'd0;
            next_y = y_addr + 9'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            x_addr       <= '0;
            y_addr       <= '0;
            maze_addr    <= '0;
            pixel_data   <= '0;
            pixel_write  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cell_wall    <= 1'b0;
            lat_px       <= '0;
            lat_py       <= '0;
            lat_ex       <= '0;
            lat_ey       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.gen_end) begin
                        lat_px    <= bus.player_x;
                        lat_py    <= bus.player_y;
                        lat_ex    <= bus.exit_x;
                        lat_ey    <= bus.exit_y;
                        x_addr    <= '0;
                        y_addr    <= '0;
                        maze_addr <= '0;
                        busy_q    <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                // Address was registered on entry to FETCH, so it has been stable
                // for READ_LATENCY cycles when the count expires.
                WAIT: begin
                    if (wait_cnt == WCW'(READ_LATENCY - 1)) begin
                        cell_wall   <= bus.maze_address_data;
                        pixel_data  <= colour_of(x_addr, y_addr, bus.maze_address_data);
                        pixel_write <= 1'b1;
                        state       <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                PRESENT: begin
                    if (bus.pixelReady) begin
                        pixel_write <= 1'b0;
                        state       <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last_pixel) begin
                        x_addr       <= '0;
                        y_addr       <= '0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state        <= DONE;
                    end else begin
                        x_addr <= next_x;
                        y_addr <= next_y;
                        if (next_x[CELL_BITS-1:0] == '0) begin
                            maze_addr <= cell_index(next_x, next_y);
                            state     <= FETCH;
                        end else begin
                            pixel_data  <= colour_of(next_x, next_y, cell_wall);
                            pixel_write <= 1'b1;
                            state       <= PRESENT;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.maze_address = maze_addr;
    assign bus.xAddr        = x_addr;
    assign bus.yAddr        = y_addr;
    assign bus.pixelData    = pixel_data;
    assign bus.pixelWrite   = pixel_write;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Scoreboard bench for maze_pixel_renderer on a reduced 32x24 screen (4x3 cells).
// Expected pixels are queued at start and popped on every LCD accept.
module tb_maze_pixel_renderer;
    localparam int W = 32, H = 24, CB = 3, MW = 4, MH = 3, RL = 2;

    logic clock = 1'b0;
    logic reset;
    maze_pixel_renderer_if bus();

    maze_pixel_renderer #(
        .WIDTH(W), .HEIGHT(H), .CELL_BITS(CB), .MAZE_W(MW), .MAZE_H(MH),
        .READ_LATENCY(RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Maze memory: data appears RL cycles after the address changes.
    logic mem [0:MW*MH-1];
    logic d1, d2;
    always @(posedge clock) begin
        d1 <= (int'(bus.maze_address) < MW*MH) ? mem[int'(bus.maze_address)] : 1'b0;
        d2 <= d1;
    end
    assign bus.maze_address_data = d2;

    function automatic logic [63:0] pack(input int x, input int y, input int addr, input int col);
        return (64'(x) << 36) | (64'(y) << 27) | (64'(addr) << 16) | 64'(col[15:0]);
    endfunction

    function automatic int colour(input int x, input int y, input int px, input int py,
                                  input int ex, input int ey);
        int cx, cy;
        cx = x >> CB;
        cy = y >> CB;
        if (cx == px && cy == py) return 32'hF800;
        if (cx == ex && cy == ey) return 32'h001F;
        return mem[cx + MW*cy] ? 32'h0000 : 32'h07E0;
    endfunction

    logic [63:0] exp_q [$];
    int accepts, fd_cnt, fetches, run_len, hold_cycles, stall_left;
    logic stall_en;
    logic [63:0] snap;

    task automatic push_frame();
        int px, py, ex, ey;
        px = int'(bus.player_x); py = int'(bus.player_y);
        ex = int'(bus.exit_x);   ey = int'(bus.exit_y);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back(pack(x, y, (x >> CB) + MW*(y >> CB), colour(x, y, px, py, ex, ey)));
    endtask

    // Monitor and pixelReady driver; ready is updated before the accept is sampled
    // because it holds until the next negedge and so is what the posedge sees.
    initial begin
        logic [63:0] obs;
        bus.pixelReady = 1'b1;
        run_len = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                obs = pack(int'(bus.xAddr), int'(bus.yAddr), int'(bus.maze_address),
                           int'(bus.pixelData));
                bus.pixelReady = 1'b1;
                if (stall_en && bus.pixelWrite && bus.xAddr == 8'd3 && bus.yAddr == 9'd0) begin
                    hold_cycles++;
                    if (hold_cycles == 1) snap = obs;
                    else chk("stall_stable", obs, snap);
                    if (stall_left > 0) begin
                        bus.pixelReady = 1'b0;
                        stall_left--;
                    end
                end
                if (bus.pixelWrite && bus.pixelReady) begin
                    accepts++;
                    if (exp_q.size() == 0) chk("extra_accept", obs, 64'd0);
                    else chk("pixel", obs, exp_q.pop_front());
                end
                if (bus.busy && !bus.pixelWrite) run_len++;
                else begin
                    if (run_len > 1) fetches++;
                    run_len = 0;
                end
                if (bus.frame_done) fd_cnt++;
            end
        end
    end

    function automatic logic [63:0] outs();
        return {bus.maze_address, bus.xAddr, bus.yAddr, bus.pixelData,
                bus.pixelWrite, bus.busy, bus.frame_done};
    endfunction

    // hook 1: move player mid-frame; hook 2: hold start high from mid-frame until DONE.
    task automatic run_frame(input string tag, input int hook);
        int n, lat;
        bit done;
        accepts = 0; fd_cnt = 0; fetches = 0; hold_cycles = 0;
        push_frame();
        @(negedge clock);
        bus.start = 1'b1;
        n = 0; lat = -1; done = 0;
        while (!done && n < 20000) begin
            @(negedge clock);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (lat < 0 && bus.pixelWrite) lat = n;
            if (hook == 1 && n == 20) bus.player_x = 5'd2;
            if (hook == 2 && n == 50) bus.start = 1'b1;
            if (bus.frame_done) begin
                done = 1;
                bus.start = 1'b0;
            end
        end
        chk({tag, "_timeout"}, 64'(done), 64'd1);
        repeat (10) @(negedge clock);
        chk({tag, "_latency"}, 64'(lat), 64'(2 + RL));
        chk({tag, "_accepts"}, 64'(accepts), 64'(W*H));
        chk({tag, "_frame_done"}, 64'(fd_cnt), 64'd1);
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_fetches"}, 64'(fetches), 64'(MW*H));
        exp_q.delete();
    endtask

    task automatic fill_mem(input logic v);
        for (int i = 0; i < MW*MH; i++) mem[i] = v;
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        bus.start = 1'b0; bus.gen_end = 1'b0;
        bus.player_x = 5'd31; bus.player_y = 6'd63;
        bus.exit_x = 5'd20;   bus.exit_y = 6'd50;
        stall_en = 1'b0; stall_left = 0;
        fill_mem(1'b0);
        repeat (3) @(negedge clock);
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        bus.gen_end = 1'b1;

        run_frame("floor", 0);

        mem[1 + MW*1] = 1'b1;
        run_frame("one_wall", 0);

        fill_mem(1'b1);
        bus.player_x = 5'd0; bus.player_y = 6'd0;
        bus.exit_x = 5'(MW-1); bus.exit_y = 6'(MH-1);
        run_frame("player_exit", 1);

        fill_mem(1'b0);
        bus.player_x = 5'd31; bus.player_y = 6'd63;
        bus.exit_x = 5'd20;   bus.exit_y = 6'd50;
        stall_en = 1'b1; stall_left = 5;
        run_frame("stall", 0);
        chk("stall_hold_cycles", 64'(hold_cycles), 64'd6);
        stall_en = 1'b0;

        // Reset in the middle of a frame.
        fd_cnt = 0;
        push_frame();
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clock);
            if (bus.pixelWrite && bus.xAddr == 8'd20 && bus.yAddr == 9'd10) hit = 1;
        end
        chk("reset_reach_pixel", 64'(hit), 64'd1);
        #2 reset = 1'b1;
        #1 chk("reset_mid_outputs", outs(), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clock);
        chk("reset_no_frame_done", 64'(fd_cnt), 64'd0);
        run_frame("after_reset", 0);

        // start without a valid maze is ignored.
        bus.gen_end = 1'b0;
        fd_cnt = 0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        chk("no_gen_end_busy", 64'(bus.busy), 64'd0);
        chk("no_gen_end_done", 64'(fd_cnt), 64'd0);
        bus.gen_end = 1'b1;
        run_frame("start_while_busy", 2);
        repeat (20) @(negedge clock);
        chk("start_busy_ignored_busy", 64'(bus.busy), 64'd0);
        chk("start_busy_ignored_done", 64'(fd_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
